// File: rtl/video_timing_generator_pkg.sv
`default_nettype none
// ============================================================================
// video_timing_generator_pkg : System86 default geometry and axis checks
// Rev 1.0
// ============================================================================
package video_timing_generator_pkg;

  localparam int c_s86_pixel_div    = 8;
  localparam int c_s86_h_bits       = 9;
  localparam int c_s86_v_bits       = 9;
  localparam int c_s86_h_total      = 384;
  localparam int c_s86_h_active     = 288;
  localparam int c_s86_h_sync_start = 304;
  localparam int c_s86_h_sync_width = 32;
  localparam int c_s86_v_total      = 264;
  localparam int c_s86_v_active     = 224;
  localparam int c_s86_v_sync_start = 240;
  localparam int c_s86_v_sync_width = 8;
  localparam int c_s86_blank_delay  = 4;

  // Guarantees that the decode of count 0 is all-zero, so reset values are consistent.
  function automatic bit axis_params_ok(int bits, int total, int active,
                                        int sync_start, int sync_width);
    return (bits >= 1) && (bits < 31) && (active > 0) && (active <= sync_start) &&
           (sync_width >= 0) && (sync_start + sync_width <= total) &&
           (total >= 2) && (total <= (1 << bits));
  endfunction

endpackage
`default_nettype wire

// File: rtl/timing_axis_counter.sv
`default_nettype none
// ============================================================================
// timing_axis_counter : wrapping pixel/line counter with registered
// blank, sync and last-count decode. Rev 1.0
// ============================================================================
module timing_axis_counter
  import video_timing_generator_pkg::*;
#(
  parameter int BITS       = 9,
  parameter int TOTAL      = 384,
  parameter int ACTIVE     = 288,
  parameter int SYNC_START = 304,
  parameter int SYNC_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_step,
  output logic [BITS-1:0] o_count,
  output logic            o_blank,
  output logic            o_sync,
  output logic            o_last
);

  localparam logic [BITS-1:0] c_last = BITS'(TOTAL - 1);

  generate
    if (!axis_params_ok(BITS, TOTAL, ACTIVE, SYNC_START, SYNC_WIDTH)) begin : g_param_error
      $error("timing_axis_counter: inconsistent axis geometry");
    end
  endgenerate

  logic [BITS-1:0] r_count;
  logic            r_blank;
  logic            r_sync;
  logic            r_last;
  logic [BITS-1:0] w_next;
  logic [31:0]     w_next_wide;

  assign w_next      = (r_count == c_last) ? '0 : r_count + 1'b1;
  assign w_next_wide = 32'(w_next);

  // Decode from the next count so flags change on the same edge as the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_blank <= 1'b0;
      r_sync  <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_step) begin
      r_count <= w_next;
      r_blank <= (w_next_wide >= 32'(ACTIVE));
      r_sync  <= (w_next_wide >= 32'(SYNC_START)) &&
                 (w_next_wide < 32'(SYNC_START + SYNC_WIDTH));
      r_last  <= (w_next == c_last);
    end
  end

  assign o_count = r_count;
  assign o_blank = r_blank;
  assign o_sync  = r_sync;
  assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/video_timing_generator.sv
`default_nettype none
// ============================================================================
// video_timing_generator : pixel enable, H/V counters, sync, blanking and
// frame strobes from one master clock. Rev 1.0
// ============================================================================
module video_timing_generator
  import video_timing_generator_pkg::*;
#(
  parameter int C_PIXEL_DIV    = c_s86_pixel_div,
  parameter int C_H_BITS       = c_s86_h_bits,
  parameter int C_V_BITS       = c_s86_v_bits,
  parameter int C_H_TOTAL      = c_s86_h_total,
  parameter int C_H_ACTIVE     = c_s86_h_active,
  parameter int C_H_SYNC_START = c_s86_h_sync_start,
  parameter int C_H_SYNC_WIDTH = c_s86_h_sync_width,
  parameter int C_V_TOTAL      = c_s86_v_total,
  parameter int C_V_ACTIVE     = c_s86_v_active,
  parameter int C_V_SYNC_START = c_s86_v_sync_start,
  parameter int C_V_SYNC_WIDTH = c_s86_v_sync_width,
  parameter int C_BLANK_DELAY  = c_s86_blank_delay
) (
  input  logic                CLK_48M,
  input  logic                RESET,
  input  logic                ENABLE,
  output logic                PCLK_EN,
  output logic                PCLK_EN_D,
  output logic [C_H_BITS-1:0] H_COUNT,
  output logic [C_V_BITS-1:0] V_COUNT,
  output logic                HSYNC,
  output logic                VSYNC,
  output logic                HBLANK,
  output logic                VBLANK,
  output logic                BLANKING,
  output logic                COMPSYNC,
  output logic                HRESET,
  output logic                VRESET,
  output logic                FIELD
);

  localparam int                  c_div_bits = (C_PIXEL_DIV > 2) ? $clog2(C_PIXEL_DIV) : 1;
  localparam logic [c_div_bits-1:0] c_div_last = c_div_bits'(C_PIXEL_DIV - 1);

  generate
    if ((C_PIXEL_DIV < 2) || (C_BLANK_DELAY < 0) || (C_BLANK_DELAY > 15)) begin : g_param_error
      $error("video_timing_generator: C_PIXEL_DIV or C_BLANK_DELAY out of range");
    end
  endgenerate

  logic [c_div_bits-1:0] r_div;
  logic                  r_pclk_en_d;
  logic                  r_field;
  logic                  w_pclk_en;
  logic                  w_v_step;
  logic                  w_h_last;
  logic                  w_v_last;
  logic                  w_blank_now;

  // Pixel enable is masked by ENABLE so a hold never leaks a stray strobe.
  assign w_pclk_en = ENABLE && (r_div == c_div_last);
  assign w_v_step  = w_pclk_en && w_h_last;

  always_ff @(posedge CLK_48M or posedge RESET) begin
    if (RESET) begin
      r_div       <= '0;
      r_pclk_en_d <= 1'b0;
      r_field     <= 1'b0;
    end else if (ENABLE) begin
      r_div       <= (r_div == c_div_last) ? '0 : r_div + 1'b1;
      r_pclk_en_d <= w_pclk_en;
      if (w_v_step && w_v_last) begin
        r_field <= ~r_field;
      end
    end
  end

  timing_axis_counter #(
    .BITS(C_H_BITS), .TOTAL(C_H_TOTAL), .ACTIVE(C_H_ACTIVE),
    .SYNC_START(C_H_SYNC_START), .SYNC_WIDTH(C_H_SYNC_WIDTH)
  ) u_h_axis (
    .clk(CLK_48M), .rst(RESET), .i_step(w_pclk_en),
    .o_count(H_COUNT), .o_blank(HBLANK), .o_sync(HSYNC), .o_last(w_h_last)
  );

  timing_axis_counter #(
    .BITS(C_V_BITS), .TOTAL(C_V_TOTAL), .ACTIVE(C_V_ACTIVE),
    .SYNC_START(C_V_SYNC_START), .SYNC_WIDTH(C_V_SYNC_WIDTH)
  ) u_v_axis (
    .clk(CLK_48M), .rst(RESET), .i_step(w_v_step),
    .o_count(V_COUNT), .o_blank(VBLANK), .o_sync(VSYNC), .o_last(w_v_last)
  );

  assign w_blank_now = HBLANK | VBLANK;

  generate
    if (C_BLANK_DELAY == 0) begin : g_blank_direct
      assign BLANKING = w_blank_now;
    end else begin : g_blank_delay
      logic [C_BLANK_DELAY-1:0] r_blank_sr;
      always_ff @(posedge CLK_48M or posedge RESET) begin
        if (RESET) begin
          r_blank_sr <= '0;
        end else if (w_pclk_en) begin
          r_blank_sr[0] <= w_blank_now;
          for (int i = 1; i < C_BLANK_DELAY; i++) begin
            r_blank_sr[i] <= r_blank_sr[i-1];
          end
        end
      end
      assign BLANKING = r_blank_sr[C_BLANK_DELAY-1];
    end
  endgenerate

  assign PCLK_EN   = w_pclk_en;
  assign PCLK_EN_D = r_pclk_en_d && ENABLE;
  assign COMPSYNC  = HSYNC | VSYNC;
  assign HRESET    = w_h_last;
  assign VRESET    = w_h_last && w_v_last;
  assign FIELD     = r_field;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_generator.sv
`default_nettype none
// Directed bench for video_timing_generator on a 10x5 raster with pixel divide 2.
module tb_video_timing_generator;

  logic       CLK_48M = 1'b0;
  logic       RESET   = 1'b1;
  logic       ENABLE  = 1'b1;
  logic       PCLK_EN, PCLK_EN_D;
  logic [3:0] H_COUNT;
  logic [2:0] V_COUNT;
  logic       HSYNC, VSYNC, HBLANK, VBLANK, BLANKING, COMPSYNC, HRESET, VRESET, FIELD;

  int n_vec = 0;
  int n_err = 0;
  int g_pix = 0;

  video_timing_generator #(
    .C_PIXEL_DIV(2), .C_H_BITS(4), .C_V_BITS(3),
    .C_H_TOTAL(10), .C_H_ACTIVE(6), .C_H_SYNC_START(7), .C_H_SYNC_WIDTH(2),
    .C_V_TOTAL(5), .C_V_ACTIVE(3), .C_V_SYNC_START(3), .C_V_SYNC_WIDTH(1),
    .C_BLANK_DELAY(1)
  ) dut (
    .CLK_48M(CLK_48M), .RESET(RESET), .ENABLE(ENABLE),
    .PCLK_EN(PCLK_EN), .PCLK_EN_D(PCLK_EN_D),
    .H_COUNT(H_COUNT), .V_COUNT(V_COUNT),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .HBLANK(HBLANK), .VBLANK(VBLANK),
    .BLANKING(BLANKING), .COMPSYNC(COMPSYNC),
    .HRESET(HRESET), .VRESET(VRESET), .FIELD(FIELD)
  );

  always #5 CLK_48M = ~CLK_48M;

  logic [8:0] act_flags;
  assign act_flags = {HSYNC, VSYNC, HBLANK, VBLANK, BLANKING, COMPSYNC, HRESET, VRESET, FIELD};

  // Expected {HSYNC,VSYNC,HBLANK,VBLANK,BLANKING,COMPSYNC,HRESET,VRESET,FIELD} for pixel q since restart.
  function automatic logic [8:0] exp_flags(int q);
    int  h, v;
    logic hs, vs, hb, vb, bl, hr, vr, fld;
    h   = q % 10;
    v   = (q / 10) % 5;
    hb  = (h >= 6);
    vb  = (v >= 3);
    hs  = (h == 7) || (h == 8);
    vs  = (v == 3);
    hr  = (h == 9);
    vr  = hr && (v == 4);
    fld = ((q / 50) % 2) == 1;
    bl  = (q == 0) ? 1'b0 : ((((q - 1) % 10) >= 6) || ((((q - 1) / 10) % 5) >= 3));
    return {hs, vs, hb, vb, bl, hs | vs, hr, vr, fld};
  endfunction

  function automatic logic [6:0] exp_counts(int q);
    logic [3:0] h;
    logic [2:0] v;
    h = 4'(q % 10);
    v = 3'((q / 10) % 5);
    return {h, v};
  endfunction

  task automatic tick();
    @(posedge CLK_48M);
    #1;
  endtask

  // From the second clock of pixel g_pix to the second clock of the next pixel.
  task automatic advance_pixel();
    tick();
    tick();
    g_pix++;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_vec++;
    if ({PCLK_EN, PCLK_EN_D, act_flags} !== 11'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, want %b", {PCLK_EN, PCLK_EN_D, act_flags}, 11'b0);
    end
    n_vec++;
    if ({H_COUNT, V_COUNT} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_counts: got %h, want 00", {H_COUNT, V_COUNT});
    end
    RESET = 1'b0;
    tick();
    n_vec++;
    if ({PCLK_EN, PCLK_EN_D, H_COUNT, V_COUNT} !== {2'b10, 7'b0}) begin
      n_err++;
      $display("FAIL first_pclk: got %b, want %b", {PCLK_EN, PCLK_EN_D, H_COUNT, V_COUNT}, {2'b10, 7'b0});
    end
    g_pix = 0;
  endtask

  task automatic test_raster(int n_pix);
    for (int i = 0; i < n_pix; i++) begin
      n_vec++;
      if ({PCLK_EN, PCLK_EN_D, H_COUNT, V_COUNT} !== {2'b10, exp_counts(g_pix)}) begin
        n_err++;
        $display("FAIL raster_pclk_phase q=%0d: got %b, want %b", g_pix,
                 {PCLK_EN, PCLK_EN_D, H_COUNT, V_COUNT}, {2'b10, exp_counts(g_pix)});
      end
      n_vec++;
      if (act_flags !== exp_flags(g_pix)) begin
        n_err++;
        $display("FAIL raster_flags q=%0d: got %b, want %b", g_pix, act_flags, exp_flags(g_pix));
      end
      tick();
      g_pix++;
      n_vec++;
      if ({PCLK_EN, PCLK_EN_D, H_COUNT, V_COUNT} !== {2'b01, exp_counts(g_pix)}) begin
        n_err++;
        $display("FAIL raster_idle_phase q=%0d: got %b, want %b", g_pix,
                 {PCLK_EN, PCLK_EN_D, H_COUNT, V_COUNT}, {2'b01, exp_counts(g_pix)});
      end
      n_vec++;
      if (act_flags !== exp_flags(g_pix)) begin
        n_err++;
        $display("FAIL raster_flags_idle q=%0d: got %b, want %b", g_pix, act_flags, exp_flags(g_pix));
      end
      tick();
    end
  endtask

  task automatic test_enable_hold();
    for (int k = 0; k < 10 && (g_pix % 10) != 4; k++) advance_pixel();
    ENABLE = 1'b0;
    #1;
    n_vec++;
    if (PCLK_EN !== 1'b0) begin
      n_err++;
      $display("FAIL hold_pclk_forced: got %b, want 0", PCLK_EN);
    end
    for (int k = 0; k < 7; k++) begin
      tick();
      n_vec++;
      if ({PCLK_EN, PCLK_EN_D, H_COUNT, act_flags} !== {2'b00, 4'd4, exp_flags(g_pix)}) begin
        n_err++;
        $display("FAIL hold_frozen clk=%0d: got %b, want %b", k,
                 {PCLK_EN, PCLK_EN_D, H_COUNT, act_flags}, {2'b00, 4'd4, exp_flags(g_pix)});
      end
    end
    ENABLE = 1'b1;
    #1;
    n_vec++;
    if ({PCLK_EN, H_COUNT} !== {1'b1, 4'd4}) begin
      n_err++;
      $display("FAIL resume_pclk: got %b, want %b", {PCLK_EN, H_COUNT}, {1'b1, 4'd4});
    end
    tick();
    g_pix++;
    n_vec++;
    if ({PCLK_EN, PCLK_EN_D, H_COUNT} !== {2'b01, 4'd5}) begin
      n_err++;
      $display("FAIL resume_next_pixel: got %b, want %b", {PCLK_EN, PCLK_EN_D, H_COUNT}, {2'b01, 4'd5});
    end
    tick();
    test_raster(12);
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 100 && (g_pix % 100) != 75; k++) advance_pixel();
    n_vec++;
    if ({FIELD, V_COUNT, H_COUNT} !== {1'b1, 3'd2, 4'd5}) begin
      n_err++;
      $display("FAIL pre_reset_position: got %b, want %b", {FIELD, V_COUNT, H_COUNT}, {1'b1, 3'd2, 4'd5});
    end
    #2;
    RESET = 1'b1;
    #1;
    n_vec++;
    if ({PCLK_EN, PCLK_EN_D, act_flags, H_COUNT, V_COUNT} !== 18'b0) begin
      n_err++;
      $display("FAIL async_reset_clear: got %b, want %b", {PCLK_EN, PCLK_EN_D, act_flags, H_COUNT, V_COUNT}, 18'b0);
    end
    tick();
    RESET = 1'b0;
    tick();
    g_pix = 0;
    test_raster(12);
  endtask

  initial begin
    test_reset();
    test_raster(61);
    test_enable_hold();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
